ad5543_spi_dac_driver: RTL and testbench

- Serial front-end for the AD5543 16-bit current-output DAC.
- Accepts one parallel sample per frame over a valid/ready handshake and shifts it MSB-first on SDI with a divided SCLK, framed by CS_N.
- Each CS_N rising edge loads the DAC register.
- Sits between a sample source (e.g. the orthogonal DDS, whose enable is driven by ready) and the DAC pins. The frame length fixes the DAC update rate.

---
 rtl/ad5543_pkg.sv | 25 ++
 rtl/ad5543_frame_timer.sv | 79 +++++++
 rtl/ad5543_spi_dac_driver.sv | 127 ++++++++++++
 tb/tb_ad5543_spi_dac_driver.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad5543_pkg.sv
// ad5543_pkg
// Shared definitions for the AD5543 serial DAC driver:
//   - default DW / PERIOD / SCLK_DIV values
//   - cs_rise_cycle(): frame-counter value at which CS_N rises and the DAC loads
//   - frame_state_e: IDLE (no frame), SHIFT (CS_N low, bits on the wire),
//     DONE (frame finished, waiting for the counter to wrap)
package ad5543_pkg;

  localparam int DEF_DW       = 16;
  localparam int DEF_PERIOD   = 96;
  localparam int DEF_SCLK_DIV = 2;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } frame_state_e;

  // Each bit occupies 2*sclk_div cycles starting at cnt=1, so CS_N rises
  // right after the last bit span.
  function automatic int cs_rise_cycle(input int dw, input int sclk_div);
    return 2 * sclk_div * dw + 1;
  endfunction

endpackage

// File: rtl/ad5543_frame_timer.sv
// ad5543_frame_timer
// Owns the frame counter (0..PERIOD-1), the once-per-frame ready strobe and
// the bit/phase decode. Decode outputs describe the counter value of the NEXT
// cycle so the top level can register its pins and have them line up with cnt.
// Ports:
//   aclk, areset_n   clock, asynchronous active-low reset
//   en               block enable
//   busy             a frame is on the wire (keeps the counter running)
//   in_ready         en && cnt==0, forced low during reset
//   nxt_sclk         sclk level for the next cycle's bit span
//   nxt_bit_start    next cycle starts a new bit span (sdi may change)
//   nxt_cs_rise      next cycle is the CS_N rise / DAC load cycle
//   nxt_wrap         next cycle the counter is 0
module ad5543_frame_timer
  import ad5543_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int PERIOD   = DEF_PERIOD,
  parameter int SCLK_DIV = DEF_SCLK_DIV
) (
  input  logic aclk,
  input  logic areset_n,
  input  logic en,
  input  logic busy,
  output logic in_ready,
  output logic nxt_sclk,
  output logic nxt_bit_start,
  output logic nxt_cs_rise,
  output logic nxt_wrap
);

  localparam int CW      = $clog2(PERIOD);
  localparam int CS_RISE = cs_rise_cycle(DW, SCLK_DIV);

  localparam logic [CW-1:0] LAST_CNT    = CW'(PERIOD - 1);
  localparam logic [CW-1:0] CS_RISE_CNT = CW'(CS_RISE);
  localparam logic [CW-1:0] SPAN_CNT    = CW'(2 * SCLK_DIV);
  localparam logic [CW-1:0] HALF_CNT    = CW'(SCLK_DIV);
  localparam logic [CW-1:0] ONE_CNT     = CW'(1);

  if (PERIOD < CS_RISE + 1) begin : g_bad_period
    $error("ad5543_frame_timer: PERIOD must be >= 2*SCLK_DIV*DW+2");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] idx;
  logic [CW-1:0] phase;
  logic          nxt_in_frame;

  // An idle, disabled block parks the counter at 0 so re-enabling produces
  // the ready strobe immediately.
  always_comb begin
    cnt_d = '0;
    if (busy || en) begin
      cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + ONE_CNT;
    end
  end

  always_comb begin
    idx           = cnt_d - ONE_CNT;
    phase         = idx % SPAN_CNT;
    nxt_in_frame  = (cnt_d != '0) && (cnt_d < CS_RISE_CNT);
    nxt_bit_start = nxt_in_frame && (phase == '0);
    nxt_sclk      = nxt_in_frame && (phase >= HALF_CNT);
    nxt_cs_rise   = (cnt_d == CS_RISE_CNT);
    nxt_wrap      = (cnt_d == '0);
  end

  assign in_ready = areset_n && en && (cnt_q == '0);

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ad5543_spi_dac_driver.sv
// ad5543_spi_dac_driver
// Serial front-end for the AD5543 16-bit DAC. One sample is accepted per frame
// (in_ready && in_valid) and shifted MSB-first on sdi with a divided sclk,
// framed by cs_n; the cs_n rising edge loads the DAC.
// Optional build macro AD5543_TWOS_COMPLEMENT_IN_EN: in_data is two's
// complement and its MSB is inverted at capture to give offset binary.
// Ports:
//   aclk, areset_n   clock, asynchronous active-low reset
//   en               block enable (only matters at frame boundaries)
//   in_valid/in_ready/in_data   sample handshake; in_ready pulses once per frame
//   sclk, sdi, cs_n  registered DAC pins (sclk idles low, cs_n idles high)
module ad5543_spi_dac_driver
  import ad5543_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int PERIOD   = DEF_PERIOD,
  parameter int SCLK_DIV = DEF_SCLK_DIV
) (
  input  logic          aclk,
  input  logic          areset_n,
  input  logic          en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          sclk,
  output logic          sdi,
  output logic          cs_n
);

  frame_state_e  state_q, state_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic [DW-1:0] cap_data;
  logic          sclk_q, sclk_d;
  logic          sdi_q, sdi_d;
  logic          cs_n_q, cs_n_d;
  logic          accept;
  logic          nxt_sclk;
  logic          nxt_bit_start;
  logic          nxt_cs_rise;
  logic          nxt_wrap;

  ad5543_frame_timer #(
    .DW       (DW),
    .PERIOD   (PERIOD),
    .SCLK_DIV (SCLK_DIV)
  ) u_timer (
    .aclk          (aclk),
    .areset_n      (areset_n),
    .en            (en),
    .busy          (state_q == SHIFT),
    .in_ready      (in_ready),
    .nxt_sclk      (nxt_sclk),
    .nxt_bit_start (nxt_bit_start),
    .nxt_cs_rise   (nxt_cs_rise),
    .nxt_wrap      (nxt_wrap)
  );

  assign accept = in_ready && in_valid;

  always_comb begin
    cap_data = in_data;
`ifdef AD5543_TWOS_COMPLEMENT_IN_EN
    cap_data[DW-1] = ~in_data[DW-1];
`endif
  end

  // The MSB goes out together with the cs_n fall; every later bit span start
  // (sclk falling edge) presents the next bit from the shift register.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    sdi_d   = sdi_q;
    sclk_d  = 1'b0;
    cs_n_d  = 1'b1;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          shreg_d = cap_data;
          sdi_d   = cap_data[DW-1];
          cs_n_d  = 1'b0;
        end
      end
      SHIFT: begin
        cs_n_d = 1'b0;
        sclk_d = nxt_sclk;
        if (nxt_cs_rise) begin
          state_d = DONE;
          cs_n_d  = 1'b1;
          sclk_d  = 1'b0;
        end else if (nxt_bit_start) begin
          shreg_d = {shreg_q[DW-2:0], 1'b0};
          sdi_d   = shreg_q[DW-2];
        end
      end
      DONE: begin
        if (nxt_wrap) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      sclk_q  <= 1'b0;
      sdi_q   <= 1'b0;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      sdi_q   <= sdi_d;
      cs_n_q  <= cs_n_d;
    end
  end

  assign sclk = sclk_q;
  assign sdi  = sdi_q;
  assign cs_n = cs_n_q;

endmodule

// File: tb/tb_ad5543_spi_dac_driver.sv
// tb_ad5543_spi_dac_driver
// Drives frames into the AD5543 driver, compares the pins cycle by cycle
// against a timing model, and decodes each cs_n frame into a DAC value that is
// checked against a queue of expected words.
module tb_ad5543_spi_dac_driver;

  localparam int DW      = 16;
  localparam int PERIOD  = 96;
  localparam int H       = 2;
  localparam int CS_RISE = 2 * H * DW + 1;

  logic          aclk = 1'b0;
  logic          areset_n;
  logic          en;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          sclk;
  logic          sdi;
  logic          cs_n;

  int checks = 0;
  int errors = 0;

  ad5543_spi_dac_driver #(
    .DW       (DW),
    .PERIOD   (PERIOD),
    .SCLK_DIV (H)
  ) dut (
    .aclk     (aclk),
    .areset_n (areset_n),
    .en       (en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .sclk     (sclk),
    .sdi      (sdi),
    .cs_n     (cs_n)
  );

  always #5 aclk = ~aclk;

  function automatic logic [DW-1:0] to_wire(input logic [DW-1:0] d);
`ifdef AD5543_TWOS_COMPLEMENT_IN_EN
    return {~d[DW-1], d[DW-2:0]};
`else
    return d;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Timing model: cnt, busy and the word on the wire, with pin values derived
  // from the frame position.
  int            m_cnt  = 0;
  int            m_nxt;
  bit            m_busy = 1'b0;
  logic [DW-1:0] m_word = '0;
  int            m_bidx;
  logic          exp_ready, exp_cs_n, exp_sclk, exp_sdi;

  always_comb begin
    m_nxt = 0;
    if (m_busy || en) m_nxt = (m_cnt == PERIOD - 1) ? 0 : m_cnt + 1;
    m_bidx = 0;
    if (m_cnt >= 1 && m_cnt <= 2 * H * DW) m_bidx = (m_cnt - 1) / (2 * H);
    exp_ready = areset_n && en && (m_cnt == 0);
    exp_cs_n  = !m_busy;
    exp_sclk  = m_busy && (((m_cnt - 1) % (2 * H)) >= H);
    exp_sdi   = m_busy ? m_word[DW-1-m_bidx] : m_word[0];
  end

  always @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      m_cnt  <= 0;
      m_busy <= 1'b0;
      m_word <= '0;
    end else begin
      m_cnt <= m_nxt;
      if (en && (m_cnt == 0) && in_valid) begin
        m_busy <= 1'b1;
        m_word <= to_wire(in_data);
      end else if (m_nxt == CS_RISE) begin
        m_busy <= 1'b0;
      end
    end
  end

  // Pin monitor and DAC model, sampled on the falling clock edge.
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] rx      = '0;
  int            rx_bits = 0;
  logic [DW-1:0] dac_val = '0;
  int            frames  = 0;
  int            readies = 0;
  logic          sclk_prev = 1'b0;
  logic          cs_prev   = 1'b1;
  bit            checking  = 1'b0;

  always @(negedge aclk) begin
    if (checking) begin
      checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
      checkOutput("cs_n", 32'(cs_n), 32'(exp_cs_n));
      checkOutput("sclk", 32'(sclk), 32'(exp_sclk));
      checkOutput("sdi", 32'(sdi), 32'(exp_sdi));
      if (in_ready) readies <= readies + 1;
      if (sclk && !sclk_prev) begin
        rx      <= {rx[DW-2:0], sdi};
        rx_bits <= rx_bits + 1;
      end
      if (!cs_n && cs_prev) rx_bits <= 0;
      if (cs_n && !cs_prev) begin
        if (!areset_n) begin
          if (sb_q.size() > 0) void'(sb_q.pop_front());
        end else begin
          frames  <= frames + 1;
          dac_val <= rx;
          checkOutput("frame_bits", 32'(rx_bits), 32'(DW));
          checkOutput("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
          if (sb_q.size() > 0) checkOutput("frame_word", 32'(rx), 32'(sb_q.pop_front()));
        end
      end
      sclk_prev <= sclk;
      cs_prev   <= cs_n;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge aclk);
      #1;
    end
  endtask

  task automatic waitCnt0();
    int guard = 0;
    while (m_cnt != 0 && guard < 2 * PERIOD) begin
      tick(1);
      guard++;
    end
    if (m_cnt != 0) checkOutput("align_timeout", 32'(m_cnt), 32'd0);
  endtask

  // Offers one sample at the ready cycle and runs the rest of the period.
  task automatic applyStimulus(input logic valid, input logic [DW-1:0] data);
    in_valid = valid;
    in_data  = data;
    if (en && (m_cnt == 0) && valid) sb_q.push_back(to_wire(data));
    tick(1);
    in_valid = 1'b0;
    in_data  = DW'($urandom);
    tick(PERIOD - 1);
  endtask

  typedef struct {
    logic          valid;
    logic [DW-1:0] data;
    int            exp_frames;
    logic [DW-1:0] exp_dac;
  } vec_t;

  vec_t vecs[$];

  initial begin : main
    int f0, r0;
    vecs.push_back('{1'b1, 16'hA5C3, 1, to_wire(16'hA5C3)});
    vecs.push_back('{1'b1, 16'h8000, 1, to_wire(16'h8000)});
    vecs.push_back('{1'b1, 16'h7FFF, 1, to_wire(16'h7FFF)});
    vecs.push_back('{1'b0, 16'h1234, 0, to_wire(16'h7FFF)});
    vecs.push_back('{1'b1, 16'h0000, 1, to_wire(16'h0000)});
    vecs.push_back('{1'b1, 16'hFFFF, 1, to_wire(16'hFFFF)});
    vecs.push_back('{1'b1, 16'hDA82, 1, to_wire(16'hDA82)});
    vecs.push_back('{1'b1, 16'h8000, 1, to_wire(16'h8000)});
    vecs.push_back('{1'b1, 16'h257E, 1, to_wire(16'h257E)});
    vecs.push_back('{1'b1, 16'h0001, 1, to_wire(16'h0001)});
    vecs.push_back('{1'b1, 16'h257E, 1, to_wire(16'h257E)});
    vecs.push_back('{1'b1, 16'hDA82, 1, to_wire(16'hDA82)});

    areset_n = 1'b1;
    en       = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #2 areset_n = 1'b0;
    #1;
    checkOutput("rst_cs_n", 32'(cs_n), 32'd1);
    checkOutput("rst_sclk", 32'(sclk), 32'd0);
    checkOutput("rst_sdi", 32'(sdi), 32'd0);
    en = 1'b1;
    #1;
    checkOutput("rst_ready", 32'(in_ready), 32'd0);
    checking = 1'b1;
    tick(2);
    areset_n = 1'b1;
    #1;
    checkOutput("ready_after_reset", 32'(in_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      waitCnt0();
      f0 = frames;
      r0 = readies;
      applyStimulus(vecs[i].valid, vecs[i].data);
      checkOutput($sformatf("vec%0d_frames", i), 32'(frames - f0), 32'(vecs[i].exp_frames));
      checkOutput($sformatf("vec%0d_dac", i), 32'(dac_val), 32'(vecs[i].exp_dac));
      checkOutput($sformatf("vec%0d_ready_once", i), 32'(readies - r0), 32'd1);
    end

    // en dropped mid-frame: the frame finishes, then the block parks.
    waitCnt0();
    f0 = frames;
    in_valid = 1'b1;
    in_data  = 16'h3C5A;
    sb_q.push_back(to_wire(16'h3C5A));
    tick(1);
    in_valid = 1'b0;
    tick(19);
    checkOutput("en_drop_at_cnt20", 32'(m_cnt), 32'd20);
    en = 1'b0;
    r0 = readies;
    tick(150);
    checkOutput("en_drop_frames", 32'(frames - f0), 32'd1);
    checkOutput("en_drop_dac", 32'(dac_val), 32'(to_wire(16'h3C5A)));
    checkOutput("en_drop_no_ready", 32'(readies - r0), 32'd0);
    en = 1'b1;
    #1;
    checkOutput("ready_on_en_rise", 32'(in_ready), 32'd1);
    tick(1);

    // Reset in the middle of a frame aborts it on the spot.
    waitCnt0();
    in_valid = 1'b1;
    in_data  = 16'h0F0F;
    sb_q.push_back(to_wire(16'h0F0F));
    tick(1);
    in_valid = 1'b0;
    tick(29);
    checkOutput("mid_frame_cs_low", 32'(cs_n), 32'd0);
    areset_n = 1'b0;
    #1;
    checkOutput("abort_cs_n", 32'(cs_n), 32'd1);
    checkOutput("abort_sclk", 32'(sclk), 32'd0);
    checkOutput("abort_ready", 32'(in_ready), 32'd0);
    tick(3);
    areset_n = 1'b1;
    #1;
    checkOutput("ready_after_abort", 32'(in_ready), 32'd1);
    f0 = frames;
    applyStimulus(1'b1, 16'h5A5A);
    checkOutput("post_abort_frames", 32'(frames - f0), 32'd1);
    checkOutput("post_abort_dac", 32'(dac_val), 32'(to_wire(16'h5A5A)));

    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    checks++;
    errors++;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
